// File: rtl/mul_div_unit_pkg.sv
// Shared multiply/divide operation codes, also used by the CU decoder.
package mdu_defs;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit for the EX stage. Holds busy for a fixed
// latency, then commits the full 64-bit result into HI/LO in a single edge.
module mul_div_unit
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter bit STALL_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        start,
  input  logic [3:0]  ctrl,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      a_p0;
  logic [31:0]      b_p0;
  logic [3:0]       op_p0;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [63:0] res_w;
  logic               res_ok;

  // Signed divide on magnitudes so the MIN/-1 case wraps to MIN instead of
  // overflowing; quotient truncates toward zero, remainder follows dividend.
  // Returns {remainder, quotient}.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, uq, ur, q, r;
    ua = a[31] ? (~a + 32'd1) : a;
    ub = b[31] ? (~b + 32'd1) : b;
    if (ub == 32'd0) begin
      uq = 32'd0;
      ur = 32'd0;
    end else begin
      uq = ua / ub;
      ur = ua % ub;
    end
    q = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
    r = a[31] ? (~ur + 32'd1) : ur;
    return {r, q};
  endfunction

  // Unsigned divide with a zero-divisor guard. Returns {remainder, quotient}.
  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  assign prod_s = $signed({{32{a_p0[31]}}, a_p0}) * $signed({{32{b_p0[31]}}, b_p0});
  assign prod_u = {32'd0, a_p0} * {32'd0, b_p0};

  // Result selection from the latched operation; divide-by-zero suppresses the write
  always_comb begin
    res_w  = 64'd0;
    res_ok = 1'b0;
    case (op_p0)
      MD_MULT: begin
        res_w  = prod_s;
        res_ok = 1'b1;
      end
      MD_MULTU: begin
        res_w  = prod_u;
        res_ok = 1'b1;
      end
      MD_DIV: begin
        res_w  = div_signed(a_p0, b_p0);
        res_ok = (b_p0 != 32'd0);
      end
      MD_DIVU: begin
        res_w  = div_unsigned(a_p0, b_p0);
        res_ok = (b_p0 != 32'd0);
      end
      default: begin
        res_w  = 64'd0;
        res_ok = 1'b0;
      end
    endcase
  end

  // Control FSM: accept in IDLE, count down in RUN, commit on the last RUN edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      a_p0  <= 32'd0;
      b_p0  <= 32'd0;
      op_p0 <= MD_NONE;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            case (ctrl)
              MD_MULT, MD_MULTU: begin
                a_p0  <= srcA;
                b_p0  <= srcB;
                op_p0 <= ctrl;
                cnt   <= MULT_N;
                busy  <= 1'b1;
                state <= MD_RUN;
              end
              MD_DIV, MD_DIVU: begin
                a_p0  <= srcA;
                b_p0  <= srcB;
                op_p0 <= ctrl;
                cnt   <= DIV_N;
                busy  <= 1'b1;
                state <= MD_RUN;
              end
              MD_MTHI: HI <= srcA;
              MD_MTLO: LO <= srcA;
              default: ;
            endcase
          end
        end
        MD_RUN: begin
          if (cnt == CNT_ONE) begin
            if (res_ok) begin
              HI <= res_w[63:32];
              LO <= res_w[31:0];
            end
            cnt   <= '0;
            busy  <= 1'b0;
            state <= MD_IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // EX is expected to stall MD-class instructions while busy is high
  always @(posedge clk) begin
    if (STALL_CHECK && reset)
      assert (!(busy && start)) else $error("mul_div_unit: start asserted while busy");
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, results, MTHI/MTLO, reset abort,
// and requests arriving while the unit is busy.
module tb_mul_div_unit;
  import mdu_defs::*;

  logic        clk;
  logic        reset;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        start;
  logic [3:0]  ctrl;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int errors = 0;
  int checks = 0;

  // Requests during busy are driven on purpose below, so the DUT-side stall check is off
  mul_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .STALL_CHECK(1'b0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .srcA (srcA),
    .srcB (srcB),
    .start(start),
    .ctrl (ctrl),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, then count busy cycles; HI/LO are captured in cycle T+1
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int n, output logic [31:0] mid_hi, output logic [31:0] mid_lo);
    @(negedge clk);
    ctrl = c; srcA = a; srcB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mid_hi = HI;
    mid_lo = LO;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  int          n;
  logic [31:0] mh, ml;

  initial begin
    reset = 1'b0; start = 1'b0; ctrl = MD_NONE; srcA = 32'd0; srcB = 32'd0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // MULT -2 * 3
    run_op(MD_MULT, 32'hFFFFFFFE, 32'd3, n, mh, ml);
    chk("mult_busy_cycles", 32'(n), 32'd5);
    chk("mult_hi_held", mh, 32'd0);
    chk("mult_lo_held", ml, 32'd0);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFA);

    // MULTU max * max
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, n, mh, ml);
    chk("multu_busy_cycles", 32'(n), 32'd5);
    chk("multu_hi_held", mh, 32'hFFFFFFFF);
    chk("multu_hi", HI, 32'hFFFFFFFE);
    chk("multu_lo", LO, 32'h00000001);

    // DIV -7 / 2
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, n, mh, ml);
    chk("div_busy_cycles", 32'(n), 32'd10);
    chk("div_lo_held", ml, 32'h00000001);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);

    // DIV 7 / -2
    run_op(MD_DIV, 32'd7, 32'hFFFFFFFE, n, mh, ml);
    chk("div_neg_lo", LO, 32'hFFFFFFFD);
    chk("div_neg_hi", HI, 32'h00000001);

    // DIV MIN / -1
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, n, mh, ml);
    chk("div_ovf_lo", LO, 32'h80000000);
    chk("div_ovf_hi", HI, 32'h00000000);

    // DIVU 7 / 2
    run_op(MD_DIVU, 32'd7, 32'd2, n, mh, ml);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    // DIVU 7 / 0 leaves HI/LO alone after a full divide latency
    run_op(MD_DIVU, 32'd7, 32'd0, n, mh, ml);
    chk("divu0_busy_cycles", 32'(n), 32'd10);
    chk("divu0_lo", LO, 32'd3);
    chk("divu0_hi", HI, 32'd1);

    // MD_NONE and an undefined code do nothing
    @(negedge clk);
    ctrl = MD_NONE; srcA = 32'hFFFF0000; start = 1'b1;
    @(negedge clk);
    chk("none_busy", {31'd0, busy}, 32'd0);
    ctrl = 4'hF;
    @(negedge clk);
    start = 1'b0;
    chk("undef_busy", {31'd0, busy}, 32'd0);
    chk("undef_hi", HI, 32'd1);
    chk("undef_lo", LO, 32'd3);

    // MTHI then MTLO back to back
    ctrl = MD_MTHI; srcA = 32'h12345678; srcB = 32'd0; start = 1'b1;
    @(negedge clk);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", HI, 32'h12345678);
    chk("mthi_lo", LO, 32'd3);
    ctrl = MD_MTLO; srcA = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("mtlo_lo", LO, 32'h9ABCDEF0);
    chk("mtlo_hi", HI, 32'h12345678);

    // Reset in cycle T+3 aborts a MULT
    @(negedge clk);
    ctrl = MD_MULT; srcA = 32'd3; srcB = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_commit_busy", {31'd0, busy}, 32'd0);
    chk("abort_no_commit_lo", LO, 32'd0);
    chk("abort_no_commit_hi", HI, 32'd0);

    // Requests and operand changes during RUN are ignored, including at the commit edge
    ctrl = MD_MULT; srcA = 32'd4; srcB = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    srcA = 32'd100; srcB = 32'd100;
    chk("ign_busy_t1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    ctrl = MD_MULT; srcA = 32'd7; srcB = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ign_busy_t5", {31'd0, busy}, 32'd1);
    chk("ign_lo_held", LO, 32'd0);
    ctrl = MD_MULT; srcA = 32'd9; srcB = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy_t6", {31'd0, busy}, 32'd0);
    chk("ign_lo", LO, 32'd20);
    chk("ign_hi", HI, 32'd0);
    @(negedge clk);
    chk("ign_busy_t7", {31'd0, busy}, 32'd0);
    chk("ign_lo_final", LO, 32'd20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
